nq_decode_stage: RTL and testbench

- Decode/issue stage of the NanoQuarter CPU; the producing end of the execute-stage interface (Integration2).
- Accepts 16-bit instructions from fetch via a valid/ready handshake and decodes the fields.
- Reads an 8x16 register file that is written back from execute (regwrite/mmuxout).
- Registers all execute-stage inputs in one pipeline register; detects load-use hazards and handles flush.

---
 rtl/nq_pkg.sv | 23 ++
 rtl/nq_decode_stage_if.sv | 20 ++
 rtl/nq_regfile.sv | 24 ++
 rtl/nq_decode_stage.sv | 73 +++++++
 tb/tb_nq_decode_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/nq_pkg.sv
// nq_pkg: NanoQuarter decode encodings, field positions, FSM states and source-use helpers.
package nq_pkg;
  typedef enum logic [1:0] {OP_R = 2'b00, OP_I = 2'b01, OP_J = 2'b10, OP_B = 2'b11} op_t;
  typedef enum logic [1:0] {RUN, LU_STALL, WB_STALL} state_t;
  localparam logic [2:0] F_LUI = 3'd0, F_LBI = 3'd1, F_SUI = 3'd2, F_SBI = 3'd3, F_LW = 3'd4, F_SW = 3'd5;
  localparam logic [2:0] F_JMP = 3'd0, F_JR = 3'd1, F_BNE = 3'd0, F_ADD = 3'd5;
  localparam int OP_HI = 15, OP_LO = 14, RD_HI = 13, RD_LO = 11, RS_HI = 10, RS_LO = 8;
  localparam int RT_HI = 7, RT_LO = 5, IMM_HI = 10, IMM_LO = 3, SH_HI = 4, SH_LO = 3;
  function automatic logic [2:0] src1(logic [15:0] i);
    return i[OP_HI:OP_LO] == OP_R ? i[RS_HI:RS_LO] : i[RD_HI:RD_LO];
  endfunction
  function automatic logic [2:0] src2(logic [15:0] i);
    return i[OP_HI:OP_LO] == OP_B ? i[RS_HI:RS_LO] : i[RT_HI:RT_LO];
  endfunction
  // Only sources an instruction really consumes can create a hazard
  function automatic logic reads(logic [15:0] i, logic [2:0] r);
    logic u1, u2;
    u1 = i[OP_HI:OP_LO] == OP_R || (i[OP_HI:OP_LO] == OP_I && i[2:0] == F_SW) ||
         (i[OP_HI:OP_LO] == OP_J && i[2:0] == F_JR) || (i[OP_HI:OP_LO] == OP_B && i[2:0] == F_BNE);
    u2 = i[OP_HI:OP_LO] == OP_R || (i[OP_HI:OP_LO] == OP_B && i[2:0] == F_BNE);
    return (u1 && src1(i) == r) || (u2 && src2(i) == r);
  endfunction
endpackage

// File: rtl/nq_decode_stage_if.sv
// nq_decode_stage_if: decode-to-execute pipeline register bundle.
interface nq_decode_stage_if #(parameter int PCW = 32);
  logic valid_out;
  logic [1:0] op_out;
  logic [2:0] funct_out;
  logic [1:0] shamt_out;
  logic [15:0] reg1data_out, reg2data_out;
  logic [7:0] idata_out, jtarget_out;
  logic [5:0] memaddr_out;
  logic [4:0] boffset_out;
  logic [2:0] dest_out;
  logic bne_out, jmp_out, jr_out, memread_out, memwrite_out, regwrite_out;
  logic [PCW-1:0] PC_out;
  modport master(output valid_out, op_out, funct_out, shamt_out, reg1data_out, reg2data_out, idata_out,
                 jtarget_out, memaddr_out, boffset_out, dest_out, bne_out, jmp_out, jr_out, memread_out,
                 memwrite_out, regwrite_out, PC_out);
  modport slave(input valid_out, op_out, funct_out, shamt_out, reg1data_out, reg2data_out, idata_out,
                jtarget_out, memaddr_out, boffset_out, dest_out, bne_out, jmp_out, jr_out, memread_out,
                memwrite_out, regwrite_out, PC_out);
endinterface

// File: rtl/nq_regfile.sv
// nq_regfile: 8x16 register file, one write and two combinational read ports; write-first under NQ_WB_BYPASS_EN.
module nq_regfile #(parameter int NREGS = 8) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd1,
  output logic [15:0] rd2
);
  logic [15:0] regs [NREGS];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    else if (we) regs[wa] <= wd;
`ifdef NQ_WB_BYPASS_EN
  assign rd1 = we && wa == ra1 ? wd : regs[ra1];
  assign rd2 = we && wa == ra2 ? wd : regs[ra2];
`else
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
`endif
endmodule

// File: rtl/nq_decode_stage.sv
// nq_decode_stage: NanoQuarter decode/issue with load-use stall and flush.
// NQ_WB_BYPASS_EN: write-first register reads; otherwise same-cycle writeback conflicts take a WB_STALL.
module nq_decode_stage import nq_pkg::*; #(
  parameter int NREGS = 8,
  parameter int PCW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    instr_in,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [PCW-1:0] pc_in,
  input  logic           flush,
  input  logic           wb_regwrite,
  input  logic [2:0]     wb_dest,
  input  logic [15:0]    wb_data,
  nq_decode_stage_if.master ex
);
  state_t state, state_n;
  logic [15:0] rdata1, rdata2;
  logic [1:0] op;
  logic [2:0] fn;
  logic [5:0] flags;
  logic lu_haz, wb_haz, acc;
  nq_regfile #(.NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst), .we(wb_regwrite), .wa(wb_dest), .wd(wb_data),
    .ra1(src1(instr_in)), .ra2(src2(instr_in)), .rd1(rdata1), .rd2(rdata2)
  );
  assign op = instr_in[OP_HI:OP_LO];
  assign fn = instr_in[2:0];
  assign flags = {op == OP_B && fn == F_BNE, op == OP_J && (fn == F_JMP || fn == F_JR), op == OP_J && fn == F_JR,
                  op == OP_I && fn == F_LW, op == OP_I && fn == F_SW,
                  op == OP_R || (op == OP_I && (fn == F_LUI || fn == F_LBI || fn == F_LW))};
  assign lu_haz = instr_valid && ex.valid_out && ex.memread_out && reads(instr_in, ex.dest_out);
`ifdef NQ_WB_BYPASS_EN
  assign wb_haz = 1'b0;
`else
  assign wb_haz = instr_valid && wb_regwrite && reads(instr_in, wb_dest);
`endif
  // The stall state only blocks re-detection, so a hazard costs exactly one not-ready cycle
  always_comb begin
    instr_ready = !rst && !(state == RUN && (lu_haz || wb_haz));
    state_n = flush || state != RUN ? RUN : lu_haz ? LU_STALL : wb_haz ? WB_STALL : RUN;
  end
  assign acc = instr_valid && instr_ready && !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      ex.valid_out <= 1'b0;
      {ex.bne_out, ex.jmp_out, ex.jr_out, ex.memread_out, ex.memwrite_out, ex.regwrite_out} <= '0;
      {ex.op_out, ex.funct_out, ex.shamt_out, ex.idata_out, ex.jtarget_out} <= '0;
      {ex.memaddr_out, ex.boffset_out, ex.dest_out} <= '0;
      {ex.reg1data_out, ex.reg2data_out} <= '0;
      ex.PC_out <= '0;
    end else begin
      state <= state_n;
      ex.valid_out <= acc;
      {ex.bne_out, ex.jmp_out, ex.jr_out, ex.memread_out, ex.memwrite_out, ex.regwrite_out} <= acc ? flags : 6'b0;
      if (acc) begin
        ex.op_out <= op;
        ex.funct_out <= fn;
        ex.shamt_out <= instr_in[SH_HI:SH_LO];
        ex.idata_out <= instr_in[IMM_HI:IMM_LO];
        ex.jtarget_out <= instr_in[IMM_HI:IMM_LO];
        ex.memaddr_out <= instr_in[8:3];
        ex.boffset_out <= instr_in[7:3];
        ex.dest_out <= instr_in[RD_HI:RD_LO];
        ex.reg1data_out <= rdata1;
        ex.reg2data_out <= rdata2;
        ex.PC_out <= pc_in;
      end
    end
endmodule

// File: tb/tb_nq_decode_stage.sv
// tb_nq_decode_stage: directed plus randomized stimulus against an instruction-level reference model.
module tb_nq_decode_stage;
`ifdef NQ_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] instr_in = '0, wb_data = '0;
  logic instr_valid = 1'b0, flush = 1'b0, wb_regwrite = 1'b0;
  logic [31:0] pc_in = '0;
  logic [2:0] wb_dest = '0;
  logic instr_ready;
  int n_chk = 0, n_err = 0;
  logic [15:0] m_regs [8];
  logic m_stalled, e_valid;
  logic [5:0] e_flags;
  logic [15:0] e_instr, e_r1, e_r2;
  logic [31:0] e_pc;

  always #5 clk = ~clk;

  nq_decode_stage_if #(.PCW(32)) ex();
  nq_decode_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_in(pc_in), .flush(flush), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest), .wb_data(wb_data), .ex(ex)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] flags_of(input logic [15:0] i);
    case (i[15:14])
      2'b00: return 6'b000001;
      2'b01: case (i[2:0])
        3'd0, 3'd1: return 6'b000001;
        3'd4: return 6'b000101;
        3'd5: return 6'b000010;
        default: return 6'b000000;
      endcase
      2'b10: case (i[2:0])
        3'd0: return 6'b010000;
        3'd1: return 6'b011000;
        default: return 6'b000000;
      endcase
      default: return i[2:0] == 3'd0 ? 6'b100000 : 6'b000000;
    endcase
  endfunction

  function automatic bit m_reads(input logic [15:0] i, input logic [2:0] r);
    case (i[15:14])
      2'b00: return i[10:8] == r || i[7:5] == r;
      2'b01: return i[2:0] == 3'd5 && i[13:11] == r;
      2'b10: return i[2:0] == 3'd1 && i[13:11] == r;
      default: return i[2:0] == 3'd0 && (i[13:11] == r || i[10:8] == r);
    endcase
  endfunction

  function automatic logic [15:0] m_rd(input logic [2:0] idx);
    return (BYP && wb_regwrite && wb_dest == idx) ? wb_data : m_regs[idx];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
    m_stalled = 0; e_valid = 0; e_flags = '0; e_instr = '0; e_r1 = '0; e_r2 = '0; e_pc = '0;
  endtask

  task automatic chk_outs();
    logic [1:0] op;
    op = e_instr[15:14];
    check("valid", ex.valid_out, e_valid);
    check("flags", {ex.bne_out, ex.jmp_out, ex.jr_out, ex.memread_out, ex.memwrite_out, ex.regwrite_out}, e_flags);
    check("op", ex.op_out, op);
    check("funct", ex.funct_out, e_instr[2:0]);
    check("shamt", ex.shamt_out, e_instr[4:3]);
    check("idata", ex.idata_out, e_instr[10:3]);
    check("jtarget", ex.jtarget_out, e_instr[10:3]);
    check("memaddr", ex.memaddr_out, e_instr[8:3]);
    check("boffset", ex.boffset_out, e_instr[7:3]);
    check("reg1", ex.reg1data_out, e_r1);
    if (op == 2'b00 || op == 2'b11) check("reg2", ex.reg2data_out, e_r2);
    if (op == 2'b00 || op == 2'b01) check("dest", ex.dest_out, e_instr[13:11]);
    check("pc", ex.PC_out, e_pc);
  endtask

  // One clock: drive, check ready before the edge, advance model, check registered outputs
  task automatic cyc(input logic [15:0] i, input logic v, input logic [31:0] pc, input logic fl,
                     input logic ww, input logic [2:0] wd, input logic [15:0] wdat);
    bit haz, exp_ready, acc;
    instr_in = i; instr_valid = v; pc_in = pc; flush = fl; wb_regwrite = ww; wb_dest = wd; wb_data = wdat;
    #1;
    haz = v && ((e_valid && e_flags[2] && m_reads(i, e_instr[13:11])) || (!BYP && ww && m_reads(i, wd)));
    exp_ready = m_stalled || !haz;
    check("ready", instr_ready, exp_ready);
    acc = v && exp_ready && !fl;
    @(posedge clk);
    if (acc) begin
      e_instr = i;
      e_pc = pc;
      e_r1 = m_rd(i[15:14] == 2'b00 ? i[10:8] : i[13:11]);
      e_r2 = m_rd(i[15:14] == 2'b11 ? i[10:8] : i[7:5]);
    end
    e_flags = acc ? flags_of(i) : 6'b0;
    e_valid = acc;
    m_stalled = !fl && !m_stalled && haz;
    if (ww) m_regs[wd] = wdat;
    #1;
    chk_outs();
  endtask

  initial begin
    m_reset();
    #12;
    check("rst_ready", instr_ready, 1'b0);
    chk_outs();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(16'h0000, 0, 0, 0, 1, 3'd2, 16'h080F);
    cyc(16'h0000, 0, 0, 0, 1, 3'd3, 16'h0001);
    cyc(16'h0A6D, 1, 32'h100, 0, 0, 0, 0);
    check("add_reg1", ex.reg1data_out, 16'h080F);
    check("add_reg2", ex.reg2data_out, 16'h0001);
    check("add_shamt", ex.shamt_out, 2'b01);
    cyc(16'h4D50, 1, 32'h102, 0, 0, 0, 0);
    check("lui_idata", ex.idata_out, 8'hAA);
    check("lui_regwrite", ex.regwrite_out, 1'b1);
    cyc(16'h4D53, 1, 32'h104, 0, 0, 0, 0);
    check("sbi_regwrite", ex.regwrite_out, 1'b0);
    cyc(16'h68AC, 1, 32'h106, 0, 0, 0, 0);
    check("lw_memaddr", ex.memaddr_out, 6'b010101);
    cyc(16'h0DA5, 1, 32'h108, 0, 0, 0, 0);
    check("lu_bubble", ex.valid_out, 1'b0);
    cyc(16'h0DA5, 1, 32'h108, 0, 0, 0, 0);
    check("lu_issue", ex.valid_out, 1'b1);
    cyc(16'h8600, 1, 32'h10A, 0, 0, 0, 0);
    check("jmp_target", ex.jtarget_out, 8'hC0);
    cyc(16'hCA70, 1, 32'h10C, 0, 0, 0, 0);
    check("bne_off", ex.boffset_out, 5'b01110);
    cyc(16'h0A6D, 1, 32'h10E, 1, 0, 0, 0);
    check("flush_valid", ex.valid_out, 1'b0);
    cyc(16'h0A6D, 1, 32'h110, 0, 1, 3'd3, 16'h1234);
`ifndef NQ_WB_BYPASS_EN
    check("wb_stall", ex.valid_out, 1'b0);
    cyc(16'h0A6D, 1, 32'h110, 0, 0, 0, 0);
`endif
    check("wb_reg2", ex.reg2data_out, 16'h1234);
    cyc(16'h68AC, 1, 32'h112, 0, 0, 0, 0);
    cyc(16'h0DA5, 1, 32'h114, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("arst_ready", instr_ready, 1'b0);
    chk_outs();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(16'h0A6D, 1, 32'h200, 0, 0, 0, 0);
    check("arst_reg1", ex.reg1data_out, 16'h0000);
    check("arst_reg2", ex.reg2data_out, 16'h0000);
    for (int n = 0; n < 600; n++) begin
      logic [15:0] i;
      i = 16'($urandom);
      if ($urandom_range(0, 3) == 0) i = {2'b01, i[13:3], 3'd4};
      cyc(i, $urandom_range(0, 4) != 0, $urandom, $urandom_range(0, 9) == 0,
          $urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
